// File: rtl/alu_cmd_ctrl_if.sv
// Byte-stream, ALU and transmit-side signals of the ALU command controller.
// The master modport is the controller; the slave modport is its environment.
interface alu_cmd_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 16
);
    logic [7:0]            RX_P_DATA;
    logic                  RX_D_VLD;
    logic [DATA_WIDTH-1:0] ALU_A;
    logic [DATA_WIDTH-1:0] ALU_B;
    logic [3:0]            ALU_FUN;
    logic                  ALU_EN;
    logic [OUT_WIDTH-1:0]  ALU_OUT;
    logic                  ALU_OUT_VLD;
    logic [7:0]            TX_P_DATA;
    logic                  TX_D_VLD;
    logic                  TX_READY;
    logic                  BUSY;

    modport master (
        input  RX_P_DATA, RX_D_VLD, ALU_OUT, ALU_OUT_VLD, TX_READY,
        output ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, BUSY
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD, ALU_OUT, ALU_OUT_VLD, TX_READY,
        input  ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, BUSY
    );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// ALU command controller: assembles 0xCC/0xDD frames from RX bytes, runs the ALU and
// returns its result LSB first. Define ALU_CTRL_TIMEOUT_EN to add the ALU response watchdog.
module alu_cmd_ctrl #(
    parameter int DATA_WIDTH     = 16,
    parameter int OUT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic          CLK,
    input  logic          RST,
    alu_cmd_ctrl_if.master bus
);

    localparam logic [7:0] CMD_FULL  = 8'hCC;
    localparam logic [7:0] CMD_REUSE = 8'hDD;

    typedef enum logic [3:0] {
        IDLE,
        RX_A0,
        RX_A1,
        RX_B0,
        RX_B1,
        RX_FUN,
        ALU_WAIT,
        TX_LO,
        TX_HI
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [3:0]            fun_q, fun_d;
    logic [OUT_WIDTH-1:0]  res_q, res_d;
    logic                  en_q, en_d;
    logic                  tx_vld_q, tx_vld_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  busy_q, busy_d;
    logic                  tmo_hit;

`ifdef ALU_CTRL_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter sits at zero outside ALU_WAIT, so it is already cleared on entry.
    always_comb begin
        cnt_d = '0;
        if (state_q == ALU_WAIT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        fun_d   = fun_q;
        res_d   = res_q;

        case (state_q)
            IDLE: begin
                if (bus.RX_D_VLD) begin
                    if (bus.RX_P_DATA == CMD_FULL) begin
                        state_d = RX_A0;
                    end else if (bus.RX_P_DATA == CMD_REUSE) begin
                        state_d = RX_FUN;
                    end
                end
            end
            RX_A0: begin
                if (bus.RX_D_VLD) begin
                    a_d[7:0] = bus.RX_P_DATA;
                    state_d  = RX_A1;
                end
            end
            RX_A1: begin
                if (bus.RX_D_VLD) begin
                    a_d[15:8] = bus.RX_P_DATA;
                    state_d   = RX_B0;
                end
            end
            RX_B0: begin
                if (bus.RX_D_VLD) begin
                    b_d[7:0] = bus.RX_P_DATA;
                    state_d  = RX_B1;
                end
            end
            RX_B1: begin
                if (bus.RX_D_VLD) begin
                    b_d[15:8] = bus.RX_P_DATA;
                    state_d   = RX_FUN;
                end
            end
            RX_FUN: begin
                if (bus.RX_D_VLD) begin
                    fun_d   = bus.RX_P_DATA[3:0];
                    state_d = ALU_WAIT;
                end
            end
            ALU_WAIT: begin
                if (bus.ALU_OUT_VLD) begin
                    res_d   = bus.ALU_OUT;
                    state_d = TX_LO;
                end else if (tmo_hit) begin
                    res_d   = OUT_WIDTH'(16'hEEEE);
                    state_d = TX_LO;
                end
            end
            TX_LO: begin
                if (tx_vld_q && bus.TX_READY) begin
                    state_d = TX_HI;
                end
            end
            TX_HI: begin
                if (tx_vld_q && bus.TX_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        en_d      = (state_d == ALU_WAIT);
        busy_d    = (state_d != IDLE);
        tx_vld_d  = 1'b0;
        tx_data_d = 8'h00;
        if (state_d == TX_LO) begin
            tx_vld_d  = 1'b1;
            tx_data_d = res_d[7:0];
        end else if (state_d == TX_HI) begin
            tx_vld_d  = 1'b1;
            tx_data_d = res_d[15:8];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            fun_q     <= '0;
            res_q     <= '0;
            en_q      <= 1'b0;
            tx_vld_q  <= 1'b0;
            tx_data_q <= 8'h00;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            fun_q     <= fun_d;
            res_q     <= res_d;
            en_q      <= en_d;
            tx_vld_q  <= tx_vld_d;
            tx_data_q <= tx_data_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.ALU_A     = a_q;
    assign bus.ALU_B     = b_q;
    assign bus.ALU_FUN   = fun_q;
    assign bus.ALU_EN    = en_q;
    assign bus.TX_D_VLD  = tx_vld_q;
    assign bus.TX_P_DATA = tx_data_q;
    assign bus.BUSY      = busy_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl with a registered ALU model answering one cycle after ALU_EN.
module tb_alu_cmd_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_cmd_ctrl_if #(.DATA_WIDTH(16), .OUT_WIDTH(16)) bus ();

    alu_cmd_ctrl #(
        .DATA_WIDTH    (16),
        .OUT_WIDTH     (16),
        .TIMEOUT_CYCLES(256)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] alu_val  = 16'h0000;
    logic        alu_resp = 1'b1;
    int          en_windows = 0;
    int          tx_count   = 0;
    logic        en_prev    = 1'b0;

    // Registered ALU stand-in: valid follows enable by one clock.
    always @(posedge clk) begin
        if (rst) begin
            bus.ALU_OUT_VLD <= 1'b0;
            bus.ALU_OUT     <= 16'h0000;
        end else begin
            bus.ALU_OUT_VLD <= bus.ALU_EN & alu_resp;
            bus.ALU_OUT     <= alu_val;
        end
    end

    always @(posedge clk) begin
        en_prev <= bus.ALU_EN;
        if (bus.ALU_EN && !en_prev) en_windows <= en_windows + 1;
        if (bus.TX_D_VLD && bus.TX_READY) tx_count <= tx_count + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.RX_P_DATA = b;
        bus.RX_D_VLD  = 1'b1;
        @(negedge clk);
        bus.RX_D_VLD  = 1'b0;
    endtask

    task automatic get_tx(input string tag, output logic [7:0] b);
        b = 8'h00;
        for (int i = 0; i < 50; i++) begin
            if (bus.TX_D_VLD && bus.TX_READY) begin
                b = bus.TX_P_DATA;
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        check_val({tag, "_tx_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_A"},     32'(bus.ALU_A),     32'h0);
        check_val({tag, "_B"},     32'(bus.ALU_B),     32'h0);
        check_val({tag, "_FUN"},   32'(bus.ALU_FUN),   32'h0);
        check_val({tag, "_EN"},    32'(bus.ALU_EN),    32'h0);
        check_val({tag, "_TXD"},   32'(bus.TX_P_DATA), 32'h0);
        check_val({tag, "_TXV"},   32'(bus.TX_D_VLD),  32'h0);
        check_val({tag, "_BUSY"},  32'(bus.BUSY),      32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [7:0] b0, b1;
        int         en0, tx0, cnt;

        bus.RX_P_DATA = 8'h00;
        bus.RX_D_VLD  = 1'b0;
        bus.TX_READY  = 1'b1;
        rst           = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Full frame with cycle-exact latency checks
        alu_val = 16'hCAFE;
        en0 = en_windows;
        send_byte(8'hCC); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'h0F); send_byte(8'h00); send_byte(8'h02);
        check_val("full_A",   32'(bus.ALU_A),   32'h1234);
        check_val("full_B",   32'(bus.ALU_B),   32'h000F);
        check_val("full_FUN", 32'(bus.ALU_FUN), 32'h2);
        check_val("full_EN_n1", 32'(bus.ALU_EN), 32'h1);
        check_val("full_BUSY",  32'(bus.BUSY),   32'h1);
        @(negedge clk);
        check_val("full_EN_n2",  32'(bus.ALU_EN),   32'h1);
        check_val("full_TXV_n2", 32'(bus.TX_D_VLD), 32'h0);
        @(negedge clk);
        check_val("full_EN_n3",  32'(bus.ALU_EN),    32'h0);
        check_val("full_TXV_n3", 32'(bus.TX_D_VLD),  32'h1);
        check_val("full_lo",     32'(bus.TX_P_DATA), 32'hFE);
        @(negedge clk);
        check_val("full_TXV_n4", 32'(bus.TX_D_VLD),  32'h1);
        check_val("full_hi",     32'(bus.TX_P_DATA), 32'hCA);
        @(negedge clk);
        check_val("full_BUSY_end", 32'(bus.BUSY),     32'h0);
        check_val("full_TXV_end",  32'(bus.TX_D_VLD), 32'h0);
        check_val("full_en_windows", 32'(en_windows - en0), 32'd1);

        // Reuse frame keeps operands, new function
        alu_val = 16'hBEEF;
        en0 = en_windows;
        send_byte(8'hDD); send_byte(8'h15);
        check_val("reuse_A",   32'(bus.ALU_A),   32'h1234);
        check_val("reuse_B",   32'(bus.ALU_B),   32'h000F);
        check_val("reuse_FUN", 32'(bus.ALU_FUN), 32'h5);
        get_tx("reuse_lo", b0);
        get_tx("reuse_hi", b1);
        check_val("reuse_lo", 32'(b0), 32'hEF);
        check_val("reuse_hi", 32'(b1), 32'hBE);
        check_val("reuse_BUSY_end", 32'(bus.BUSY), 32'h0);
        check_val("reuse_en_windows", 32'(en_windows - en0), 32'd1);

        // Non-command bytes in IDLE are discarded
        en0 = en_windows;
        tx0 = tx_count;
        send_byte(8'h55);
        check_val("junk55_BUSY", 32'(bus.BUSY), 32'h0);
        send_byte(8'h00);
        check_val("junk00_BUSY", 32'(bus.BUSY), 32'h0);
        repeat (4) @(negedge clk);
        check_val("junk_en",  32'(en_windows - en0), 32'd0);
        check_val("junk_tx",  32'(tx_count - tx0),   32'd0);
        check_val("junk_FUN", 32'(bus.ALU_FUN),      32'h5);

        // TX backpressure holds the low byte
        alu_val = 16'hCAFE;
        bus.TX_READY = 1'b0;
        send_byte(8'hDD); send_byte(8'h02);
        cnt = 0;
        while (!bus.TX_D_VLD && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check_val("bp_vld_seen", 32'(bus.TX_D_VLD), 32'h1);
        tx0 = tx_count;
        for (int i = 0; i < 5; i++) begin
            check_val("bp_hold_vld",  32'(bus.TX_D_VLD),  32'h1);
            check_val("bp_hold_data", 32'(bus.TX_P_DATA), 32'hFE);
            @(negedge clk);
        end
        check_val("bp_no_transfer", 32'(tx_count - tx0), 32'd0);
        bus.TX_READY = 1'b1;
        @(negedge clk);
        check_val("bp_hi_after_ready", 32'(bus.TX_P_DATA), 32'hCA);
        check_val("bp_one_transfer",   32'(tx_count - tx0), 32'd1);
        get_tx("bp_hi", b1);
        check_val("bp_hi", 32'(b1), 32'hCA);
        check_val("bp_BUSY_end", 32'(bus.BUSY), 32'h0);

        // Reset mid-frame, with a byte strobe in the reset cycle
        send_byte(8'hCC); send_byte(8'h34);
        check_val("rstmid_BUSY_before", 32'(bus.BUSY), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        bus.RX_P_DATA = 8'hDD;
        bus.RX_D_VLD  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.RX_D_VLD = 1'b0;
        check_reset_outputs("rstmid");
        repeat (2) @(negedge clk);
        check_val("rstmid_byte_dropped", 32'(bus.BUSY), 32'h0);
        alu_val = 16'h0042;
        send_byte(8'hDD); send_byte(8'h00);
        check_val("post_rst_A",   32'(bus.ALU_A),   32'h0);
        check_val("post_rst_B",   32'(bus.ALU_B),   32'h0);
        check_val("post_rst_FUN", 32'(bus.ALU_FUN), 32'h0);
        get_tx("post_rst_lo", b0);
        get_tx("post_rst_hi", b1);
        check_val("post_rst_lo", 32'(b0), 32'h42);
        check_val("post_rst_hi", 32'(b1), 32'h00);

        // ALU never answers
        alu_resp = 1'b0;
        send_byte(8'hDD); send_byte(8'h03);
`ifdef ALU_CTRL_TIMEOUT_EN
        cnt = 0;
        while (bus.ALU_EN && cnt < 400) begin
            cnt++;
            @(negedge clk);
        end
        check_val("tmo_en_cycles", 32'(cnt), 32'd256);
        get_tx("tmo_lo", b0);
        get_tx("tmo_hi", b1);
        check_val("tmo_lo", 32'(b0), 32'hEE);
        check_val("tmo_hi", 32'(b1), 32'hEE);
        check_val("tmo_BUSY_end", 32'(bus.BUSY), 32'h0);
`else
        repeat (300) @(negedge clk);
        check_val("wait_EN_held",   32'(bus.ALU_EN),   32'h1);
        check_val("wait_BUSY_held", 32'(bus.BUSY),     32'h1);
        check_val("wait_no_tx",     32'(bus.TX_D_VLD), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("wait_rst");
`endif
        alu_resp = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
